// File: rtl/vram_scheduler_if.sv
// Requester command/response bus plus the single-port VRAM bus of vram_scheduler.
// slave = scheduler side; master = requesters and RAM.
interface vram_scheduler_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_scheduler.sv
// Single-port VRAM time-slot scheduler: scan-out fetch every PIX_PER_WORD visible pixels,
// round-robin sharing of the remaining cycles. Optional macro VRAM_BLANK_ONLY_EN.
module vram_scheduler #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 32,
  parameter int PIX_PER_WORD = 4,
  parameter int H_VISIBLE    = 1024,
  parameter int V_VISIBLE    = 768,
  localparam int PIX_W       = DATA_W / PIX_PER_WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      i_vga_x,
  input  logic [31:0]      i_vga_y,
  input  logic             i_vga_blank,
  vram_scheduler_if.slave  bus,
  output logic [PIX_W-1:0] o_pix_data,
  output logic             o_pix_valid
);
  localparam int WORDS_PER_LINE = H_VISIBLE / PIX_PER_WORD;
  localparam int PIX_SH         = $clog2(PIX_PER_WORD);

  generate
    if (((PIX_PER_WORD & (PIX_PER_WORD - 1)) != 0) || ((DATA_W % PIX_PER_WORD) != 0) ||
        ((H_VISIBLE % PIX_PER_WORD) != 0) || (V_VISIBLE < 1)) begin : g_bad_cfg
      $error("vram_scheduler: invalid geometry parameters");
    end
  endgenerate

  logic              w_disp_slot;
  logic              w_req_window;
  logic [ADDR_W-1:0] w_disp_addr;
  logic [1:0]        w_req;
  logic [1:0]        w_we;
  logic [1:0]        w_gnt;
  logic [1:0]        w_rvalid;

  logic              r_last_gnt1;
  logic              r_disp_pend;
  logic [DATA_W-1:0] r_shift;
  logic [1:0]        r_blank_dly;

  assign w_req = {bus.req1, bus.req0};
  assign w_we  = {bus.we1, bus.we0};

  assign w_disp_slot = i_vga_blank && ((i_vga_x & 32'(PIX_PER_WORD - 1)) == 32'd0);
  assign w_disp_addr = ADDR_W'(i_vga_y) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(i_vga_x >> PIX_SH);

`ifdef VRAM_BLANK_ONLY_EN
  // Tear-free mode: requesters only touch VRAM while nothing is being scanned out.
  assign w_req_window = ~i_vga_blank;
`else
  assign w_req_window = ~w_disp_slot;
`endif

  // r_last_gnt1 = 1 means requester 1 won last, so requester 0 wins the next tie.
  always_comb begin
    w_gnt = 2'b00;
    if (reset && w_req_window) begin
      if (w_req == 2'b11) begin
        w_gnt = r_last_gnt1 ? 2'b01 : 2'b10;
      end else begin
        w_gnt = w_req;
      end
    end
  end

  assign bus.gnt0 = w_gnt[0];
  assign bus.gnt1 = w_gnt[1];

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (reset && w_disp_slot) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = w_disp_addr;
    end else if (w_gnt[0]) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.we0;
      bus.ram_addr  = bus.addr0;
      bus.ram_wdata = bus.wdata0;
    end else if (w_gnt[1]) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.we1;
      bus.ram_addr  = bus.addr1;
      bus.ram_wdata = bus.wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_gnt1 <= 1'b1;
    end else if (w_gnt[0]) begin
      r_last_gnt1 <= 1'b0;
    end else if (w_gnt[1]) begin
      r_last_gnt1 <= 1'b1;
    end
  end

  // Per-requester read tag: the RAM answers one cycle after the grant.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_tag
    logic r_tag;
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_tag <= 1'b0;
      end else begin
        r_tag <= w_gnt[gi] & ~w_we[gi];
      end
    end
    assign w_rvalid[gi] = r_tag;
  end

  assign bus.rvalid0 = w_rvalid[0];
  assign bus.rvalid1 = w_rvalid[1];
  assign bus.rdata   = bus.ram_rdata;

  // Fetched word lands in the shift register one cycle after the RAM answers,
  // which lines pixel 0 up with vga_x+2 of the fetching cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_disp_pend <= 1'b0;
      r_shift     <= '0;
      r_blank_dly <= 2'b00;
    end else begin
      r_disp_pend <= w_disp_slot;
      r_blank_dly <= {r_blank_dly[0], i_vga_blank};
      if (r_disp_pend) begin
        r_shift <= bus.ram_rdata;
      end else begin
        r_shift <= r_shift >> PIX_W;
      end
    end
  end

  assign o_pix_valid = r_blank_dly[1];
  assign o_pix_data  = r_blank_dly[1] ? r_shift[PIX_W-1:0] : '0;

endmodule
